// File: rtl/datapath_multiplicacao.sv
// ---------------------------------------------------------------------------
// datapath_multiplicacao
//
// Shift-and-add datapath for an 8x8 unsigned multiplier. An external control
// FSM sequences it one multiplier bit per cycle; this block holds the
// operands, the bit-index counter, the running sum and the registered result.
//
// Ports
//   Clk        in   1   rising-edge clock
//   Rst        in   1   synchronous active-high reset
//   A          in   8   multiplicand (unsigned), loaded while limpaCont=1
//   B          in   8   multiplier   (unsigned), loaded while limpaCont=1
//   ativCont   in   1   counter select: 0 = increment, 1 = hold
//   acumula    in   1   accumulator select: 0 = add partial product, 1 = hold
//   limpaCont  in   1   idle/load: clear counter and accumulator, load operands
//   contador   out  3   current bit index, fed back to the control FSM
//   Produto    out  16  last completed product
//   Pronto     out  1   one-cycle pulse when Produto shows a new result
// ---------------------------------------------------------------------------
module datapath_multiplicacao (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        ativCont,
    input  logic        acumula,
    input  logic        limpaCont,
    output logic [2:0]  contador,
    output logic [15:0] Produto,
    output logic        Pronto
);

    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [2:0]  r_contador;
    logic [15:0] r_produto;
    logic        r_pronto;

    logic [15:0] w_p;
    logic [15:0] w_soma;

    // Partial product for the current bit: multiplicand shifted to the bit
    // position, widened first so the shift never loses the upper bits.
    always_comb begin
        w_p = 16'd0;
        if (r_b[r_contador]) begin
            w_p = {8'd0, r_a} << r_contador;
        end else begin
            w_p = 16'd0;
        end
    end

    // Running sum including the current bit; at index 7 this is the final
    // product, so the bit-7 term never has to pass through the accumulator.
    assign w_soma = r_acc + w_p;

    // Operand, counter and accumulator registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_a        <= 8'd0;
            r_b        <= 8'd0;
            r_acc      <= 16'd0;
            r_contador <= 3'd0;
        end else if (limpaCont) begin
            // Idle/load has priority over both step controls.
            r_a        <= A;
            r_b        <= B;
            r_acc      <= 16'd0;
            r_contador <= 3'd0;
        end else begin
            if (!ativCont) begin
                r_contador <= r_contador + 3'd1;
            end else begin
                r_contador <= r_contador;
            end
            if (!acumula) begin
                r_acc <= w_soma;
            end else begin
                r_acc <= r_acc;
            end
        end
    end

    // Result capture: happens only on the last bit of a running operation,
    // so an abort through limpaCont or Rst never publishes a partial sum.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_produto <= 16'd0;
            r_pronto  <= 1'b0;
        end else if (!limpaCont && (r_contador == 3'd7)) begin
            r_produto <= w_soma;
            r_pronto  <= 1'b1;
        end else begin
            r_produto <= r_produto;
            r_pronto  <= 1'b0;
        end
    end

    assign contador = r_contador;
    assign Produto  = r_produto;
    assign Pronto   = r_pronto;

endmodule
